// File: rtl/image_bank_sequencer_pkg.sv
// Shared display definitions: ROM geometry, sequencer state encoding and
// small helpers for bank arithmetic, reused by the pixel controller.
package image_bank_sequencer_pkg;

    // 18-bit pixel ROM address and one 320x240 image per bank
    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned BANK_SIZE = 76800;
    localparam int unsigned IDX_W     = 2;

    // Sequencer: idle, or holding a queued bank change for the next frame
    typedef enum logic {
        SeqIdle,
        SeqPend
    } seq_state_e;

    // Button debouncer states
    typedef enum logic [1:0] {
        DbLow,
        DbChkHigh,
        DbHigh,
        DbChkLow
    } db_state_e;

    // ROM base address of a bank
    function automatic logic [ADDR_W-1:0] bank_base_of(input logic [IDX_W-1:0] idx,
                                                       input int unsigned size);
        int unsigned prod;
        prod = 32'(idx) * size;
        return ADDR_W'(prod);
    endfunction

    // One step up or down with wrap over num banks; a single bank never moves
    function automatic logic [IDX_W-1:0] bank_step(input logic [IDX_W-1:0] idx,
                                                   input logic up,
                                                   input int unsigned num);
        int unsigned cur;
        int unsigned nxt;
        cur = 32'(idx);
        if (num <= 1) begin
            nxt = 0;
        end else if (up) begin
            nxt = (cur >= num - 1) ? 0 : cur + 1;
        end else begin
            nxt = (cur == 0 || cur >= num) ? num - 1 : cur - 1;
        end
        return IDX_W'(nxt);
    endfunction

endpackage

// File: rtl/image_bank_sequencer_btn_debounce.sv
// Raw push-button to single-cycle press pulse: 2-flop synchronizer followed
// by a four-state debouncer. Only an accepted low-to-high edge pulses.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_press
);
    import image_bank_sequencer_pkg::*;

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       r_sync;
    db_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_sample;
    logic             w_cnt_done;

    assign w_sample   = r_sync[1];
    assign w_cnt_done = (32'(r_cnt) >= DEBOUNCE_CYCLES - 1);
    assign o_press    = r_press;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    // Accept a new level only after it is held stable; pulse on accepted press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= DbLow;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            case (r_state)
                DbLow: begin
                    if (w_sample) begin
                        r_state <= DbChkHigh;
                        r_cnt   <= '0;
                    end
                end
                DbChkHigh: begin
                    if (!w_sample) begin
                        r_state <= DbLow;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state <= DbHigh;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DbHigh: begin
                    if (!w_sample) begin
                        r_state <= DbChkLow;
                        r_cnt   <= '0;
                    end
                end
                DbChkLow: begin
                    if (w_sample) begin
                        r_state <= DbHigh;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        // Release is accepted silently
                        r_state <= DbLow;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= DbLow;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/image_bank_sequencer.sv
// Selects which stored image the pixel controller shows. Button presses and
// the slideshow timer queue a one-bank step that is only committed at
// frame_start, so the ROM base address never changes mid-frame.
module image_bank_sequencer #(
    parameter int unsigned NUM_BANKS       = 3,
    parameter int unsigned BANK_SIZE       = image_bank_sequencer_pkg::BANK_SIZE,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned AUTO_FRAMES     = 180
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       frame_start,
    input  logic                                       btn_next,
    input  logic                                       btn_prev,
    input  logic                                       auto_en,
    output logic [image_bank_sequencer_pkg::IDX_W-1:0]  bank_idx,
    output logic [image_bank_sequencer_pkg::ADDR_W-1:0] bank_base,
    output logic                                       switch_pending
);
    import image_bank_sequencer_pkg::*;

    localparam int unsigned FCNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

    seq_state_e        r_state;
    logic              r_dir_up;
    logic [IDX_W-1:0]  r_bank_idx;
    logic [ADDR_W-1:0] r_bank_base;
    logic [FCNT_W-1:0] r_frame_cnt;

    logic w_next_press;
    logic w_prev_press;
    logic w_one_press;
    logic w_any_press;
    logic w_auto_hit;
    logic w_commit_up;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_next (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn   (btn_next),
        .o_press (w_next_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_prev (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn   (btn_prev),
        .o_press (w_prev_press)
    );

    // Simultaneous next and prev cancel each other
    assign w_one_press = w_next_press ^ w_prev_press;
    assign w_any_press = w_next_press | w_prev_press;

    // Slideshow fires when this frame_start brings the count to AUTO_FRAMES-1
    assign w_auto_hit  = (32'(r_frame_cnt) + 32'd1 >= AUTO_FRAMES - 1);

    // A press landing on the committing frame_start still wins the direction
    assign w_commit_up = w_one_press ? w_next_press : r_dir_up;

    assign bank_idx       = r_bank_idx;
    assign bank_base      = r_bank_base;
    assign switch_pending = (r_state == SeqPend);

    // Slideshow frame counter; only counts frames spent idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
        end else if (!auto_en || w_any_press) begin
            r_frame_cnt <= '0;
        end else if (frame_start && (r_state == SeqIdle)) begin
            r_frame_cnt <= w_auto_hit ? '0 : r_frame_cnt + FCNT_W'(1);
        end
    end

    // Sequencer FSM: queue a direction, commit one step at frame_start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= SeqIdle;
            r_dir_up   <= 1'b1;
            r_bank_idx <= '0;
        end else begin
            case (r_state)
                SeqIdle: begin
                    if (w_one_press) begin
                        r_state  <= SeqPend;
                        r_dir_up <= w_next_press;
                    end else if (frame_start && auto_en && !w_any_press && w_auto_hit) begin
                        r_state  <= SeqPend;
                        r_dir_up <= 1'b1;
                    end
                end
                SeqPend: begin
                    if (frame_start) begin
                        r_bank_idx <= bank_step(r_bank_idx, w_commit_up, NUM_BANKS);
                        r_state    <= SeqIdle;
                    end else if (w_one_press) begin
                        r_dir_up <= w_next_press;
                    end
                end
                default: begin
                    r_state <= SeqIdle;
                end
            endcase
        end
    end

    // Base address follows bank_idx one cycle later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bank_base <= '0;
        end else begin
            r_bank_base <= bank_base_of(r_bank_idx, BANK_SIZE);
        end
    end

endmodule

// File: tb/tb_image_bank_sequencer.sv
// Bench for image_bank_sequencer: directed vector table, hand-written
// reset/cancel/slideshow sequences, then random stimulus against a model.
module tb_image_bank_sequencer;

    localparam int NB = 3;
    localparam int BS = 76800;
    localparam int DC = 4;
    localparam int AF = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic        btn_next;
    logic        btn_prev;
    logic        auto_en;
    logic [1:0]  bank_idx;
    logic [17:0] bank_base;
    logic        switch_pending;
    logic [1:0]  bank_idx1;
    logic [17:0] bank_base1;
    logic        switch_pending1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    image_bank_sequencer #(
        .NUM_BANKS       (NB),
        .BANK_SIZE       (BS),
        .DEBOUNCE_CYCLES (DC),
        .AUTO_FRAMES     (AF)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_start    (frame_start),
        .btn_next       (btn_next),
        .btn_prev       (btn_prev),
        .auto_en        (auto_en),
        .bank_idx       (bank_idx),
        .bank_base      (bank_base),
        .switch_pending (switch_pending)
    );

    // Single-bank instance shares all stimulus
    image_bank_sequencer #(
        .NUM_BANKS       (1),
        .BANK_SIZE       (BS),
        .DEBOUNCE_CYCLES (DC),
        .AUTO_FRAMES     (AF)
    ) dut1 (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_start    (frame_start),
        .btn_next       (btn_next),
        .btn_prev       (btn_prev),
        .auto_en        (auto_en),
        .bank_idx       (bank_idx1),
        .bank_base      (bank_base1),
        .switch_pending (switch_pending1)
    );

    typedef struct {
        logic  nxt;
        logic  prv;
        logic  fs;
        int    cyc;
        int    exp_idx;
        int    exp_pend;
        int    exp_base;
        string name;
    } vec_t;

    vec_t vecs[18];

    // Reference model state
    int m_bank, m_dir, m_cnt, m_base;
    bit m_pend;
    bit m_s1[2], m_s2[2], m_acc[2], m_pulse[2];
    int m_run[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int e_idx, input int e_pend,
                             input int e_base);
        check({name, "_idx"}, 32'(bank_idx), e_idx);
        check({name, "_pend"}, 32'(switch_pending), e_pend);
        check({name, "_base"}, 32'(bank_base), e_base);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        frame_start = 1'b0;
        btn_next    = 1'b0;
        btn_prev    = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic model_reset();
        m_bank = 0; m_dir = 1; m_cnt = 0; m_base = 0; m_pend = 0;
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_pulse[b] = 0; m_run[b] = 0;
        end
    endtask

    // Advance the model across one rising edge, using pre-edge values
    task automatic model_edge(input bit bn, input bit bp, input bit fs, input bit ae);
        bit np, pp, one, any, hit, was_pend, samp;
        np = m_pulse[0];
        pp = m_pulse[1];
        one = np ^ pp;
        any = np | pp;
        hit = (m_cnt + 1 >= AF - 1);
        was_pend = m_pend;
        m_base = m_bank * BS;
        if (!was_pend) begin
            if (one) begin
                m_pend = 1; m_dir = np ? 1 : -1;
            end else if (fs && ae && !any && hit) begin
                m_pend = 1; m_dir = 1;
            end
        end else if (fs) begin
            m_bank = (m_bank + (one ? (np ? 1 : -1) : m_dir) + NB) % NB;
            m_pend = 0;
        end else if (one) begin
            m_dir = np ? 1 : -1;
        end
        if (!ae || any) m_cnt = 0;
        else if (fs && !was_pend) m_cnt = hit ? 0 : m_cnt + 1;
        // A level is accepted after DC+1 consecutive synchronized samples
        for (int b = 0; b < 2; b++) begin
            samp = m_s2[b];
            m_pulse[b] = 0;
            if (samp != m_acc[b]) begin
                m_run[b]++;
                if (m_run[b] == DC + 1) begin
                    m_acc[b] = samp; m_run[b] = 0; m_pulse[b] = samp;
                end
            end else begin
                m_run[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = (b == 0) ? bn : bp;
        end
    endtask

    initial begin
        int lvl[2];
        int hold[2];
        int exp_idx;

        // Directed table: {next, prev, frame_start(first cycle), cycles, idx, pend, base}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 10, 0, 1, 0,      "next_held"};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1,  1, 0, 0,      "next_commit"};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1,  1, 0, 76800,  "next_base"};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 10, 1, 0, 76800,  "next_release"};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 10, 1, 1, 76800,  "lw_next"};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 10, 1, 1, 76800,  "lw_next_rel"};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 10, 1, 1, 76800,  "lw_prev"};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 10, 1, 1, 76800,  "lw_prev_rel"};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1,  0, 0, 76800,  "lw_commit"};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1,  0, 0, 0,      "lw_base"};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1,  0, 0, 0,      "bounce1"};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1,  0, 0, 0,      "bounce0"};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1,  0, 0, 0,      "bounce1b"};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 10, 0, 0, 0,      "bounce_settle"};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 10, 0, 1, 0,      "prev_held"};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1,  2, 0, 0,      "prev_commit"};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1,  2, 0, 153600, "prev_base"};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 10, 2, 0, 153600, "prev_release"};

        auto_en = 1'b0;
        reset_n = 1'b0;
        frame_start = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        #1;
        check_out("reset", 0, 0, 0);
        do_reset();
        check_out("reset_done", 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            btn_next    = vecs[i].nxt;
            btn_prev    = vecs[i].prv;
            frame_start = vecs[i].fs;
            for (int c = 0; c < vecs[i].cyc; c++) begin
                tick();
                frame_start = 1'b0;
            end
            check_out(vecs[i].name, vecs[i].exp_idx, vecs[i].exp_pend, vecs[i].exp_base);
        end

        // Reset mid-PEND at bank 2 discards the queued step, asynchronously
        btn_next = 1'b1;
        repeat (10) tick();
        check_out("rst_pre", 2, 1, 153600);
        #2 reset_n = 1'b0;
        #1;
        check_out("rst_async", 0, 0, 0);
        btn_next = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        check_out("rst_post_fs", 0, 0, 0);

        // Next and prev press pulses in the same cycle cancel
        btn_next = 1'b1;
        btn_prev = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("cancel_pend", 32'(switch_pending), 0);
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (10) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        check_out("cancel_fs", 0, 0, 0);

        // Slideshow: one step every AUTO_FRAMES frames
        auto_en = 1'b1;
        for (int f = 1; f <= 9; f++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            exp_idx = (f / 3) % 3;
            check("auto_idx", 32'(bank_idx), exp_idx);
            tick();
            check("auto_base", 32'(bank_base), exp_idx * BS);
            repeat (3) tick();
        end
        auto_en = 1'b0;

        // Random stimulus against the model
        do_reset();
        model_reset();
        auto_en = 1'b1;
        lvl[0] = 0; lvl[1] = 0; hold[0] = 0; hold[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < 2; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = int'($urandom_range(0, 1));
                    hold[b] = int'($urandom_range(1, 14));
                end
                hold[b]--;
            end
            btn_next    = lvl[0][0];
            btn_prev    = lvl[1][0];
            frame_start = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
            @(posedge clk);
            model_edge(btn_next, btn_prev, frame_start, auto_en);
            #1;
            check("rnd_idx", 32'(bank_idx), m_bank);
            check("rnd_pend", 32'(switch_pending), 32'(m_pend));
            check("rnd_base", 32'(bank_base), m_base);
            check("one_bank_idx", 32'(bank_idx1), 0);
            check("one_bank_base", 32'(bank_base1), 0);
            check("one_bank_pend", 32'(switch_pending1), 32'(m_pend));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/image_bank_sequencer.md
IMAGE_BANK_SEQUENCER -- requirements
Module: image_bank_sequencer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 3, meaning images stored in the 18-bit pixel ROM (legal 1..3).
REQ-002 SHALL have parameter BANK_SIZE, default 76800, meaning ROM words per 320x240 image.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning stable clk cycles required to accept a button level (10 ms at 25 MHz).
REQ-004 SHALL have parameter AUTO_FRAMES, default 180, meaning frames per image in slideshow mode.
REQ-005 SHALL have port clk, input, 1, meaning the single pixel clock; all logic is in this domain.
REQ-006 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port frame_start, input, 1, meaning one-cycle pulse on the first cycle of vertical blanking.
REQ-008 SHALL have port btn_next, input, 1, meaning raw asynchronous push-button, active-high, advance image.
REQ-009 SHALL have port btn_prev, input, 1, meaning raw asynchronous push-button, active-high, previous image.
REQ-010 SHALL have port auto_en, input, 1, meaning slideshow enable switch, sampled synchronously.
REQ-011 SHALL have port bank_idx, output, 2, meaning currently displayed image index.
REQ-012 SHALL have port bank_base, output, 18, meaning ROM base address (bank_idx*BANK_SIZE), added by the pixel controller to its pixel offset.
REQ-013 SHALL have port switch_pending, output, 1, meaning a change is queued for the next frame_start.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer, then a debouncer with states LOW, CHK_HIGH, HIGH, CHK_LOW; CHK_* advances after DEBOUNCE_CYCLES consecutive equal samples and returns to the prior state on any mismatch.
REQ-015 A debounced LOW->HIGH transition SHALL produce exactly one single-cycle press pulse; release SHALL produce no pulse.
REQ-016 The sequencer FSM SHALL have states IDLE and PEND; a press pulse in IDLE records direction (+1/-1) and enters PEND; switch_pending = (state==PEND).
REQ-017 In PEND a further press SHALL overwrite the direction (last press wins); a step is never larger than one bank.
REQ-018 Next and prev press pulses in the same cycle SHALL cancel: no state or direction change.
REQ-019 On frame_start in PEND, bank_idx SHALL step by the direction with wrap (NUM_BANKS-1 +1 -> 0, 0 -1 -> NUM_BANKS-1) and the FSM SHALL return to IDLE; the update is visible the cycle after frame_start.
REQ-020 A press pulse coinciding with frame_start in IDLE SHALL enter PEND and commit at the following frame_start.
REQ-021 bank_base SHALL be registered and equal bank_idx*BANK_SIZE one cycle after bank_idx changes; it SHALL never change except during the cycle after frame_start (tear-free).
REQ-022 With auto_en=1 a frame counter SHALL increment on each frame_start; on reaching AUTO_FRAMES-1 with state IDLE it SHALL force direction +1 into PEND and reset to 0.
REQ-023 Any manual press pulse, or auto_en=0, SHALL clear the frame counter.
REQ-024 With NUM_BANKS=1, bank_idx SHALL remain 0 under all stimulus.

Reset
REQ-025 While reset_n=0: bank_idx=0, bank_base=0, switch_pending=0, FSM IDLE, debouncers LOW with counters 0, synchronizers 0, frame counter 0.
REQ-026 Reset asserted mid-PEND SHALL discard the queued change; after deassertion the first frame_start SHALL NOT change bank_idx.

Structure
REQ-027 BANK_SIZE, the 18-bit ROM address width and the sequencer state encoding SHALL live in the shared display package for reuse by the pixel controller.
REQ-028 The synchronizer plus debouncer SHALL be one sub-module, btn_debounce, instanced per button.

Verification (DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, NUM_BANKS=3)
REQ-029 btn_next high 10 cycles, then frame_start -> one press pulse, switch_pending=1, cycle after frame_start bank_idx=1, next cycle bank_base=76800.
REQ-030 btn_prev bounce (1,0,1,0 single cycles) from bank 0 -> no pulse; then stable press plus frame_start -> bank_idx=2, bank_base=153600.
REQ-031 btn_next then btn_prev pressed before frame_start, from bank 1 -> frame_start yields bank_idx=0 (last wins), single step.
REQ-032 auto_en=1, no buttons, 9 frame_start pulses -> bank_idx sequence 1,2,0 at frames 3,6,9, bank_base matching.
REQ-033 reset_n low while switch_pending=1 at bank 2 -> outputs 0 immediately (asynchronous); post-reset frame_start leaves bank_idx=0.
REQ-034 Next and prev debounced pulses in the same cycle -> switch_pending stays 0, bank_idx unchanged after frame_start.
